// File: rtl/mvm_result_drain.sv
// Captures NUM_OLANES accumulator results per pulse, requantizes each and drains one lane per cycle.
// Optional feature: define MVM_DRAIN_RELU_EN to force negative shifted values to zero before saturation.
module mvm_result_drain #(
  parameter int unsigned IWIDTH     = 32,
  parameter int unsigned OWIDTH     = 8,
  parameter int unsigned NUM_OLANES = 27,
  parameter int unsigned LANEW      = $clog2(NUM_OLANES),
  parameter int unsigned SHW        = $clog2(IWIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IWIDTH-1:0] i_result [0:NUM_OLANES-1],
  input  logic                     i_valid,
  input  logic        [SHW-1:0]    i_shift,
  output logic signed [OWIDTH-1:0] o_data,
  output logic        [LANEW-1:0]  o_lane,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_full,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow
);

  localparam logic        [LANEW-1:0]  LastLane = LANEW'(NUM_OLANES - 1);
  localparam logic signed [IWIDTH-1:0] SatMax   = IWIDTH'((1 << (OWIDTH - 1)) - 1);
  localparam logic signed [IWIDTH-1:0] SatMin   = ~SatMax;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e                     r_state, w_state_d;
  logic signed [IWIDTH-1:0]   r_buf [0:NUM_OLANES-1];
  logic        [SHW-1:0]      r_shift;
  logic        [LANEW-1:0]    r_lane, w_lane_d;
  logic                       r_overflow, w_overflow_d;

  logic                       w_hs, w_final, w_load, w_drop;
  logic signed [IWIDTH-1:0]   w_shifted, w_clipped;
  logic signed [OWIDTH-1:0]   w_sat;

  // A capture on the final handshake edge replaces the set with no idle bubble.
  always_comb begin
    w_hs         = (r_state == StDrain) && i_ready;
    w_final      = w_hs && (r_lane == LastLane);
    w_load       = i_valid && ((r_state == StIdle) || w_final);
    w_drop       = i_valid && (r_state == StDrain) && !w_final;
    w_state_d    = r_state;
    w_lane_d     = r_lane;
    w_overflow_d = r_overflow;
    if (w_hs) begin
      w_lane_d = r_lane + 1'b1;
      if (w_final) begin
        w_state_d = StIdle;
        w_lane_d  = '0;
      end
    end
    if (w_load) begin
      w_state_d = StDrain;
      w_lane_d  = '0;
    end
    if (w_drop) begin
      w_overflow_d = 1'b1;
    end else if (i_clr_overflow) begin
      w_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_lane     <= w_lane_d;
      r_overflow <= w_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load && !rst) begin
      for (int unsigned n = 0; n < NUM_OLANES; n++) begin
        r_buf[n] <= i_result[n];
      end
      r_shift <= i_shift;
    end
  end

  always_comb begin
    w_shifted = r_buf[r_lane] >>> r_shift;
`ifdef MVM_DRAIN_RELU_EN
    w_clipped = (w_shifted < 0) ? '0 : w_shifted;
`else
    w_clipped = w_shifted;
`endif
    if (w_clipped > SatMax) begin
      w_sat = SatMax[OWIDTH-1:0];
    end else if (w_clipped < SatMin) begin
      w_sat = SatMin[OWIDTH-1:0];
    end else begin
      w_sat = w_clipped[OWIDTH-1:0];
    end
  end

  assign o_valid    = (r_state == StDrain);
  assign o_full     = (r_state == StDrain);
  assign o_lane     = r_lane;
  assign o_last     = o_valid && (r_lane == LastLane);
  assign o_data     = o_valid ? w_sat : '0;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Self-checking bench for mvm_result_drain: requant vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_mvm_result_drain;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int NL = 27;
  localparam int LW = $clog2(NL);
  localparam int SW = $clog2(IW);
  localparam longint QMax = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint QMin = -(64'sd1 <<< (OW - 1));

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] i_result [0:NL-1];
  logic                 i_valid;
  logic        [SW-1:0] i_shift;
  logic signed [OW-1:0] o_data;
  logic        [LW-1:0] o_lane;
  logic                 o_last, o_valid, i_ready, o_full, o_overflow, i_clr_overflow;

  mvm_result_drain dut (
    .clk           (clk),
    .rst           (rst),
    .i_result      (i_result),
    .i_valid       (i_valid),
    .i_shift       (i_shift),
    .o_data        (o_data),
    .o_lane        (o_lane),
    .o_last        (o_last),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_full        (o_full),
    .o_overflow    (o_overflow),
    .i_clr_overflow(i_clr_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int lane; int data; } word_t;
  word_t exp_q[$];
  bit    exp_ov;

  typedef struct { int val; int sh; int exp_plain; int exp_relu; } vec_t;
  vec_t tbl [13];

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Floor division by 2^sh, optional ReLU, then clamp to the output range.
  function automatic int requant(longint v, int sh);
    longint d = 64'sd1 <<< sh;
    longint q;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
`ifdef MVM_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > QMax) q = QMax;
    if (q < QMin) q = QMin;
    return int'(q);
  endfunction

  // Check the presented outputs, then apply one edge worth of inputs to DUT and model.
  task automatic step(bit v, bit rdy, bit clr, bit r);
    bit busy = exp_q.size() > 0;
    bit drop = 1'b0;
    chk("o_valid", o_valid, busy);
    chk("o_full", o_full, busy);
    chk("o_overflow", o_overflow, exp_ov);
    if (busy) begin
      chk("o_lane", o_lane, exp_q[0].lane);
      chk("o_data", o_data, exp_q[0].data);
      chk("o_last", o_last, exp_q[0].lane == NL - 1);
    end else begin
      chk("o_last_idle", o_last, 0);
    end
    i_valid = v; i_ready = rdy; i_clr_overflow = clr; rst = r;
    if (r) begin
      exp_q.delete();
      exp_ov = 1'b0;
    end else begin
      if (busy && rdy) void'(exp_q.pop_front());
      if (v) begin
        if (exp_q.size() == 0) begin
          for (int n = 0; n < NL; n++) exp_q.push_back('{n, requant(i_result[n], int'(i_shift))});
        end else begin
          drop = 1'b1;
          exp_ov = 1'b1;
        end
      end
      if (clr && !drop) exp_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_out(string name);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) step(0, 1, 0, 0);
    chk(name, o_full, 0);
  endtask

  initial begin
    tbl[0]  = '{40000, 0, 127, 127};
    tbl[1]  = '{-40000, 0, -128, 0};
    tbl[2]  = '{-3, 0, -3, 0};
    tbl[3]  = '{-3, 1, -2, 0};
    tbl[4]  = '{1280, 8, 5, 5};
    tbl[5]  = '{-256, 8, -1, 0};
    tbl[6]  = '{32767, 8, 127, 127};
    tbl[7]  = '{-32768, 8, -128, 0};
    tbl[8]  = '{-32769, 8, -128, 0};
    tbl[9]  = '{100, 31, 0, 0};
    tbl[10] = '{-100, 31, -1, 0};
    tbl[11] = '{32'h7fffffff, 24, 127, 127};
    tbl[12] = '{32'h80000000, 31, -1, 0};

    rst = 1'b1; i_valid = 0; i_ready = 0; i_clr_overflow = 0; i_shift = '0;
    for (int n = 0; n < NL; n++) i_result[n] = '0;
    exp_q.delete(); exp_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_lane", o_lane, 0);
    chk("rst_data", o_data, 0);

    // Requantization vectors on lane 0, each set aborted by reset.
    foreach (tbl[i]) begin
      for (int n = 0; n < NL; n++) i_result[n] = '0;
      i_result[0] = tbl[i].val;
      i_shift = SW'(tbl[i].sh);
      step(1, 0, 0, 0);
`ifdef MVM_DRAIN_RELU_EN
      chk("requant_tbl", o_data, tbl[i].exp_relu);
`else
      chk("requant_tbl", o_data, tbl[i].exp_plain);
`endif
      step(0, 0, 0, 1);
    end

    // Basic drain.
    for (int n = 0; n < NL; n++) i_result[n] = n * 256;
    i_shift = 8;
    step(1, 1, 0, 0);
    for (int n = 0; n < NL; n++) begin
      chk("basic_data", o_data, n);
      step(0, 1, 0, 0);
    end
    chk("basic_full_end", o_full, 0);

    // Backpressure, ready pattern 1,0,0,...
    for (int n = 0; n < NL; n++) i_result[n] = n * 16 - 200;
    i_shift = 4;
    step(1, 1, 0, 0);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) step(0, (c % 3) == 0, 0, 0);
    chk("bp_done", o_full, 0);

    // Overflow at lane 5.
    for (int n = 0; n < NL; n++) i_result[n] = n * 100;
    i_shift = 2;
    step(1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    chk("ovf_lane", o_lane, 5);
    for (int n = 0; n < NL; n++) i_result[n] = -7000 - n;
    step(1, 1, 0, 0);
    chk("ovf_flag", o_overflow, 1);
    drain_out("ovf_drained");
    chk("ovf_sticky", o_overflow, 1);
    step(0, 0, 1, 0);
    chk("ovf_clear", o_overflow, 0);

    // Back-to-back on the final handshake.
    for (int n = 0; n < NL; n++) i_result[n] = n - 13;
    i_shift = 0;
    step(1, 1, 0, 0);
    repeat (NL - 1) step(0, 1, 0, 0);
    chk("b2b_last", o_last, 1);
    for (int n = 0; n < NL; n++) i_result[n] = 50 + n;
    step(1, 1, 0, 0);
    chk("b2b_lane0", o_lane, 0);
    chk("b2b_data0", o_data, 50);
    chk("b2b_ovf", o_overflow, 0);
    drain_out("b2b_drained");

    // Reset mid-drain at lane 10.
    for (int n = 0; n < NL; n++) i_result[n] = n * 3;
    step(1, 1, 0, 0);
    repeat (10) step(0, 1, 0, 0);
    chk("rstmid_lane", o_lane, 10);
    step(0, 1, 0, 1);
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_full", o_full, 0);
    step(1, 1, 0, 0);
    chk("rstmid_restart", o_lane, 0);
    drain_out("rstmid_drained");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < NL; n++) i_result[n] = $signed($urandom) >>> $urandom_range(0, 31);
      i_shift = SW'($urandom_range(0, IW - 1));
      step(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 300) == 0);
    end
    drain_out("rand_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
